// File: rtl/ntru_pkg.sv
// Shared constants, poly_q encodings, FSM state codes and the q -> mask helper
// for the NTRU cyclic polynomial multiplier.
package ntru_pkg;

  localparam int unsigned CW      = 13;               // coefficient width (log2 of largest q)
  localparam int unsigned MAX_N   = 1024;             // operand RAM depth
  localparam int unsigned NW      = $clog2(MAX_N);    // index / poly_n width
  localparam int unsigned AXIS_DW = 32;               // stream data width
  localparam int unsigned A_LSB   = 0;                // a_i position in input word
  localparam int unsigned B_LSB   = 16;               // b_i position in input word

  localparam logic [1:0] Q_2048 = 2'b00;
  localparam logic [1:0] Q_4096 = 2'b01;
  localparam logic [1:0] Q_RSVD = 2'b10;
  localparam logic [1:0] Q_8192 = 2'b11;

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_OUTPUT  = 2'd2;

  // Wrap mask q-1; the reserved encoding falls back to q = 2048.
  function automatic logic [CW-1:0] q_mask(input logic [1:0] q);
    logic [CW-1:0] m;
    case (q)
      Q_4096:          m = CW'(4095);
      Q_8192:          m = CW'(8191);
      Q_2048, Q_RSVD:  m = CW'(2047);
      default:         m = CW'(2047);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ntru_polymul_core_if.sv
// One AXI4-Stream channel (tdata/tvalid/tready/tlast).
// master: drives tdata, tvalid, tlast; samples tready.
// slave : samples tdata, tvalid, tlast; drives tready.
interface ntru_polymul_core_if;
  import ntru_pkg::*;

  logic [AXIS_DW-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/ntru_coef_ram.sv
// Simple dual-port coefficient RAM, MAX_N x CW, one write port and one
// synchronous (registered) read port.
// Ports: clk; wr_en/wr_addr/wr_data write side; rd_addr in, rd_data out
// (valid the cycle after rd_addr is presented).
module ntru_coef_ram
  import ntru_pkg::*;
(
  input  logic          clk,
  input  logic          wr_en,
  input  logic [NW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic [NW-1:0] rd_addr,
  output logic [CW-1:0] rd_data
);

  logic [CW-1:0] mem [MAX_N];

  // Write and registered read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ntru_polymul_core.sv
// Streaming cyclic polynomial multiplier c(x) = a(x)*b(x) mod (x^N - 1),
// coefficients mod q (q = 2048/4096/8192), serial schoolbook MAC.
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   s_axis_mm2s       slave stream: tdata[12:0] = a_i, tdata[28:16] = b_i
//   m_axis_mm2s       master stream: tdata = {19'b0, c_k}, tlast on c_{N-1}
//   poly_n, poly_q    N and q encoding, sampled on the first input word
// Build option: define MAC_PIPE_EN to register the product before the
// accumulator (one extra drain cycle per output coefficient).
module ntru_polymul_core
  import ntru_pkg::*;
(
  input  logic                        clk,
  input  logic                        resetn,
  ntru_polymul_core_if.slave          s_axis_mm2s,
  ntru_polymul_core_if.master         m_axis_mm2s,
  input  logic [NW-1:0]               poly_n,
  input  logic [1:0]                  poly_q
);

  logic [1:0]    state_q, state_d;
  logic          s_tready_q, s_tready_d;
  logic          m_tvalid_q, m_tvalid_d;
  logic          m_tlast_q, m_tlast_d;
  logic [CW-1:0] m_tdata_q, m_tdata_d;
  logic [NW-1:0] cnt_q, cnt_d;      // load index in LOAD, term index i in COMPUTE
  logic [NW-1:0] j_q, j_d;
  logic [NW-1:0] k_q, k_d;
  logic [NW-1:0] n_q, n_d;
  logic [CW-1:0] mask_q, mask_d;
  logic          issuing_q, issuing_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_last_q, rd_last_d;
  logic [CW-1:0] acc_q, acc_d;
`ifdef MAC_PIPE_EN
  logic          mul_vld_q, mul_vld_d;
  logic          mul_last_q, mul_last_d;
  logic [CW-1:0] mul_q, mul_d;
`endif

  logic          s_hs_c, wr_en_c, term_vld_c, term_last_c;
  logic [NW-1:0] n_c, rd_addr_a_c, rd_addr_b_c;
  logic [CW-1:0] wr_mask_c, wr_a_c, wr_b_c, a_rd_c, b_rd_c;
  logic [CW-1:0] prod_c, term_c, acc_sum_c;
  logic          unused_bits_c;

  assign unused_bits_c = ^{s_axis_mm2s.tdata[31:29], s_axis_mm2s.tdata[15:13], s_axis_mm2s.tlast};

  ntru_coef_ram u_ram_a (
    .clk(clk), .wr_en(wr_en_c), .wr_addr(cnt_q), .wr_data(wr_a_c),
    .rd_addr(rd_addr_a_c), .rd_data(a_rd_c)
  );

  ntru_coef_ram u_ram_b (
    .clk(clk), .wr_en(wr_en_c), .wr_addr(cnt_q), .wr_data(wr_b_c),
    .rd_addr(rd_addr_b_c), .rd_data(b_rd_c)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    s_tready_d  = s_tready_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    m_tdata_d   = m_tdata_q;
    cnt_d       = cnt_q;
    j_d         = j_q;
    k_d         = k_q;
    n_d         = n_q;
    mask_d      = mask_q;
    issuing_d   = issuing_q;
    rd_vld_d    = 1'b0;
    rd_last_d   = 1'b0;
    acc_d       = acc_q;
    wr_en_c     = 1'b0;
    rd_addr_a_c = cnt_q;
    rd_addr_b_c = j_q;

    // The first word of a product uses the live poly_n/poly_q.
    s_hs_c    = s_axis_mm2s.tvalid && s_tready_q;
    n_c       = (cnt_q == '0) ? poly_n : n_q;
    wr_mask_c = (cnt_q == '0) ? q_mask(poly_q) : mask_q;
    wr_a_c    = s_axis_mm2s.tdata[A_LSB +: CW] & wr_mask_c;
    wr_b_c    = s_axis_mm2s.tdata[B_LSB +: CW] & wr_mask_c;

    prod_c = CW'(a_rd_c * b_rd_c) & mask_q;
`ifdef MAC_PIPE_EN
    mul_vld_d   = rd_vld_q;
    mul_last_d  = rd_last_q;
    mul_d       = prod_c;
    term_vld_c  = mul_vld_q;
    term_last_c = mul_last_q;
    term_c      = mul_q;
`else
    term_vld_c  = rd_vld_q;
    term_last_c = rd_last_q;
    term_c      = prod_c;
`endif
    acc_sum_c = (acc_q + term_c) & mask_q;

    case (state_q)
      ST_LOAD: begin
        s_tready_d = 1'b1;
        if (s_hs_c) begin
          wr_en_c = 1'b1;
          cnt_d   = cnt_q + NW'(1);
          if (cnt_q == '0) begin
            n_d    = poly_n;
            mask_d = q_mask(poly_q);
          end
          if (cnt_q == n_c - NW'(1)) begin
            s_tready_d = 1'b0;
            state_d    = ST_COMPUTE;
            cnt_d      = '0;
            j_d        = '0;
            k_d        = '0;
            acc_d      = '0;
            issuing_d  = 1'b1;
          end
        end
      end

      ST_COMPUTE: begin
        // Issue RAM reads for term i; j walks down from k, wrapping to N-1.
        if (issuing_q) begin
          rd_vld_d  = 1'b1;
          rd_last_d = (cnt_q == n_q - NW'(1));
          cnt_d     = cnt_q + NW'(1);
          j_d       = (j_q == '0) ? n_q - NW'(1) : j_q - NW'(1);
          if (cnt_q == n_q - NW'(1)) issuing_d = 1'b0;
        end
        if (term_vld_c) begin
          acc_d = acc_sum_c;
          if (term_last_c) begin
            m_tdata_d  = acc_sum_c;
            m_tvalid_d = 1'b1;
            m_tlast_d  = (k_q == n_q - NW'(1));
            state_d    = ST_OUTPUT;
          end
        end
      end

      ST_OUTPUT: begin
        if (m_axis_mm2s.tready) begin
          m_tvalid_d = 1'b0;
          m_tlast_d  = 1'b0;
          acc_d      = '0;
          cnt_d      = '0;
          if (k_q == n_q - NW'(1)) begin
            state_d    = ST_LOAD;
            s_tready_d = 1'b1;
            k_d        = '0;
            j_d        = '0;
          end else begin
            state_d   = ST_COMPUTE;
            k_d       = k_q + NW'(1);
            j_d       = k_q + NW'(1);
            issuing_d = 1'b1;
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_LOAD;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      cnt_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
      mask_q     <= '0;
      issuing_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      acc_q      <= '0;
`ifdef MAC_PIPE_EN
      mul_vld_q  <= 1'b0;
      mul_last_q <= 1'b0;
      mul_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
      cnt_q      <= cnt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      n_q        <= n_d;
      mask_q     <= mask_d;
      issuing_q  <= issuing_d;
      rd_vld_q   <= rd_vld_d;
      rd_last_q  <= rd_last_d;
      acc_q      <= acc_d;
`ifdef MAC_PIPE_EN
      mul_vld_q  <= mul_vld_d;
      mul_last_q <= mul_last_d;
      mul_q      <= mul_d;
`endif
    end
  end

  assign s_axis_mm2s.tready = s_tready_q;
  assign m_axis_mm2s.tvalid = m_tvalid_q;
  assign m_axis_mm2s.tlast  = m_tlast_q;
  assign m_axis_mm2s.tdata  = {(AXIS_DW-CW)'(0), m_tdata_q};

endmodule

// File: tb/tb_ntru_polymul_core.sv
// Self-checking bench for ntru_polymul_core: directed vectors, randomized
// products with input gaps and output stalls, back-to-back products and
// reset in the middle of a computation, against a plain-arithmetic model.
module tb_ntru_polymul_core;
  import ntru_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic [9:0] poly_n;
  logic [1:0] poly_q;

  ntru_polymul_core_if s_axis_mm2s ();
  ntru_polymul_core_if m_axis_mm2s ();

  ntru_polymul_core dut (
    .clk(clk), .resetn(resetn),
    .s_axis_mm2s(s_axis_mm2s), .m_axis_mm2s(m_axis_mm2s),
    .poly_n(poly_n), .poly_q(poly_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int va [MAX_N];
  int vb [MAX_N];
  int got [$];
  bit got_last [$];

  function automatic int q_of(input int pq);
    return (pq == 1) ? 4096 : (pq == 3) ? 8192 : 2048;
  endfunction

  // c_k = sum_i a_i * b_{(k-i) mod n}, everything reduced mod q.
  function automatic int model_coef(input int n, input int q, input int k);
    longint s = 0;
    for (int i = 0; i < n; i++)
      s = (s + longint'(va[i] % q) * longint'(vb[(k - i + n) % n] % q)) % q;
    return int'(s);
  endfunction

  task automatic send_vec(input int n, input bit gaps, output bit to);
    int i = 0;
    int cyc = 0;
    bit acc;
    to = 1'b0;
    while (i < n) begin
      s_axis_mm2s.tvalid = !(gaps && (cyc % 4 == 3));
      s_axis_mm2s.tdata  = {3'($urandom), 13'(vb[i]), 3'($urandom), 13'(va[i])};
      acc = s_axis_mm2s.tvalid && s_axis_mm2s.tready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
      if (cyc > 4 * n + 100) begin to = 1'b1; break; end
    end
    s_axis_mm2s.tvalid = 1'b0;
  endtask

  task automatic recv_vec(input int n, input bit stalls, output bit to,
                          output int unstable, output int hi_bits);
    int cyc = 0;
    bit hold = 1'b0;
    logic [31:0] held_d;
    logic held_l;
    got.delete();
    got_last.delete();
    to = 1'b0; unstable = 0; hi_bits = 0;
    while (got.size() < n) begin
      m_axis_mm2s.tready = !(stalls && (cyc % 4 == 3));
      if (hold && (m_axis_mm2s.tvalid !== 1'b1 || m_axis_mm2s.tdata !== held_d ||
                   m_axis_mm2s.tlast !== held_l)) unstable++;
      hold = 1'b0;
      if (m_axis_mm2s.tvalid) begin
        if (m_axis_mm2s.tready) begin
          got.push_back(int'(m_axis_mm2s.tdata[12:0]));
          got_last.push_back(m_axis_mm2s.tlast);
          if (m_axis_mm2s.tdata[31:13] != 19'd0) hi_bits++;
        end else begin
          hold = 1'b1; held_d = m_axis_mm2s.tdata; held_l = m_axis_mm2s.tlast;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 2 * n * (n + 4) + 500) begin to = 1'b1; break; end
    end
    m_axis_mm2s.tready = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    s_axis_mm2s.tvalid = 1'b0; s_axis_mm2s.tdata = '0; s_axis_mm2s.tlast = 1'b0;
    m_axis_mm2s.tready = 1'b0; poly_n = 10'd3; poly_q = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_axis_mm2s.tready !== 1'b0) $display("FAIL reset_tready got %b want 0", s_axis_mm2s.tready); else passes++;
    checks++; if (m_axis_mm2s.tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", m_axis_mm2s.tvalid); else passes++;
    checks++; if (m_axis_mm2s.tlast !== 1'b0) $display("FAIL reset_tlast got %b want 0", m_axis_mm2s.tlast); else passes++;
    checks++; if (m_axis_mm2s.tdata !== 32'd0) $display("FAIL reset_tdata got %h want 0", m_axis_mm2s.tdata); else passes++;
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_axis_mm2s.tready !== 1'b1) $display("FAIL load_tready got %b want 1", s_axis_mm2s.tready); else passes++;
  endtask

  task automatic test_directed;
    int ca [6][3] = '{'{1,1,0}, '{0,0,1}, '{2047,0,0}, '{4095,0,0}, '{4000,0,0}, '{3000,0,0}};
    int cb [6][3] = '{'{1,1,0}, '{0,0,1}, '{2,0,0},    '{2,0,0},    '{3,0,0},    '{2,0,0}};
    int ce [6][3] = '{'{1,2,1}, '{0,1,0}, '{2046,0,0}, '{4094,0,0}, '{3808,0,0}, '{1904,0,0}};
    int cn [6] = '{3, 3, 3, 3, 1, 1};
    int cq [6] = '{0, 0, 0, 1, 3, 2};
    bit to_s, to_r;
    int uns, hib, act;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 3; i++) begin va[i] = ca[c][i]; vb[i] = cb[c][i]; end
      poly_n = 10'(cn[c]); poly_q = 2'(cq[c]);
      send_vec(cn[c], 1'b0, to_s);
      recv_vec(cn[c], 1'b0, to_r, uns, hib);
      checks++; if ((to_s | to_r) !== 1'b0) $display("FAIL dir%0d_timeout got %b want 0", c, to_s | to_r); else passes++;
      for (int k = 0; k < cn[c]; k++) begin
        act = (k < got.size()) ? got[k] : -1;
        checks++; if (act !== ce[c][k]) $display("FAIL dir%0d_c%0d got %0d want %0d", c, k, act, ce[c][k]); else passes++;
        act = (k < got_last.size()) ? int'(got_last[k]) : -1;
        checks++; if (act !== int'(k == cn[c] - 1)) $display("FAIL dir%0d_tlast%0d got %0d want %0d", c, k, act, int'(k == cn[c] - 1)); else passes++;
      end
    end
  endtask

  task automatic test_stall;
    int n = 127, pq = 1, q, act, exp_v, uns, hib, bad = 0, extra = 0;
    bit to_s, to_r;
    q = q_of(pq);
    for (int i = 0; i < n; i++) begin va[i] = int'($urandom_range(0, 8191)); vb[i] = int'($urandom_range(0, 8191)); end
    poly_n = 10'(n); poly_q = 2'(pq);
    send_vec(n, 1'b1, to_s);
    recv_vec(n, 1'b1, to_r, uns, hib);
    checks++; if ((to_s | to_r) !== 1'b0) $display("FAIL stall_timeout got %b want 0", to_s | to_r); else passes++;
    for (int k = 0; k < n; k++) begin
      exp_v = model_coef(n, q, k);
      act = (k < got.size()) ? got[k] : -1;
      checks++; if (act !== exp_v) begin bad++; $display("FAIL stall_c%0d got %0d want %0d", k, act, exp_v); end else passes++;
      act = (k < got_last.size()) ? int'(got_last[k]) : -1;
      if (act !== int'(k == n - 1)) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL stall_words_or_tlast got %0d bad want 0", bad); else passes++;
    checks++; if (uns !== 0) $display("FAIL stall_hold_stable got %0d changes want 0", uns); else passes++;
    checks++; if (hib !== 0) $display("FAIL stall_tdata_hi got %0d words want 0", hib); else passes++;
    m_axis_mm2s.tready = 1'b1;
    repeat (6) begin
      if (m_axis_mm2s.tvalid) extra++;
      @(posedge clk); #1;
    end
    m_axis_mm2s.tready = 1'b0;
    checks++; if (extra !== 0) $display("FAIL stall_extra_words got %0d want 0", extra); else passes++;
  endtask

  task automatic test_back_to_back;
    int pn [2] = '{101, 67};
    int pp [2] = '{3, 0};
    int q, act, exp_v, uns, hib, lasts;
    bit to_s, to_r;
    for (int p = 0; p < 2; p++) begin
      q = q_of(pp[p]);
      for (int i = 0; i < pn[p]; i++) begin va[i] = int'($urandom_range(0, 8191)); vb[i] = int'($urandom_range(0, 8191)); end
      poly_n = 10'(pn[p]); poly_q = 2'(pp[p]);
      send_vec(pn[p], 1'b0, to_s);
      recv_vec(pn[p], 1'b0, to_r, uns, hib);
      checks++; if ((to_s | to_r) !== 1'b0) $display("FAIL b2b%0d_timeout got %b want 0", p, to_s | to_r); else passes++;
      lasts = 0;
      for (int k = 0; k < pn[p]; k++) begin
        exp_v = model_coef(pn[p], q, k);
        act = (k < got.size()) ? got[k] : -1;
        checks++; if (act !== exp_v) $display("FAIL b2b%0d_c%0d got %0d want %0d", p, k, act, exp_v); else passes++;
        if (k < got_last.size() && got_last[k]) lasts++;
      end
      checks++; if (lasts !== 1) $display("FAIL b2b%0d_tlast_count got %0d want 1", p, lasts); else passes++;
      act = (got_last.size() == pn[p]) ? int'(got_last[pn[p] - 1]) : -1;
      checks++; if (act !== 1) $display("FAIL b2b%0d_tlast_pos got %0d want 1", p, act); else passes++;
    end
  endtask

  task automatic test_reset_mid;
    int act, exp_v, uns, hib, rdy_seen = 0;
    bit to_s, to_r;
    for (int i = 0; i < 40; i++) begin va[i] = int'($urandom_range(0, 8191)); vb[i] = int'($urandom_range(0, 8191)); end
    poly_n = 10'd40; poly_q = 2'b00;
    send_vec(40, 1'b0, to_s);
    checks++; if (to_s !== 1'b0) $display("FAIL rmid_load_timeout got %b want 0", to_s); else passes++;
    // Inputs offered during COMPUTE must not be taken.
    repeat (20) begin
      s_axis_mm2s.tvalid = 1'b1; s_axis_mm2s.tdata = $urandom;
      if (s_axis_mm2s.tready) rdy_seen++;
      @(posedge clk); #1;
    end
    s_axis_mm2s.tvalid = 1'b0;
    checks++; if (rdy_seen !== 0) $display("FAIL rmid_compute_tready got %0d cycles want 0", rdy_seen); else passes++;
    resetn = 1'b0;
    @(posedge clk); #1;
    checks++; if (m_axis_mm2s.tvalid !== 1'b0) $display("FAIL rmid_reset_tvalid got %b want 0", m_axis_mm2s.tvalid); else passes++;
    checks++; if (s_axis_mm2s.tready !== 1'b0) $display("FAIL rmid_reset_tready got %b want 0", s_axis_mm2s.tready); else passes++;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin va[i] = int'($urandom_range(0, 8191)); vb[i] = int'($urandom_range(0, 8191)); end
    poly_n = 10'd3; poly_q = 2'b01;
    send_vec(3, 1'b0, to_s);
    recv_vec(3, 1'b0, to_r, uns, hib);
    checks++; if ((to_s | to_r) !== 1'b0) $display("FAIL rmid_fresh_timeout got %b want 0", to_s | to_r); else passes++;
    for (int k = 0; k < 3; k++) begin
      exp_v = model_coef(3, 4096, k);
      act = (k < got.size()) ? got[k] : -1;
      checks++; if (act !== exp_v) $display("FAIL rmid_c%0d got %0d want %0d", k, act, exp_v); else passes++;
    end
    act = (got_last.size() == 3) ? int'(got_last[2]) : -1;
    checks++; if (act !== 1) $display("FAIL rmid_tlast got %0d want 1", act); else passes++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
